// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and constants for the loadable instruction memory
package inst_mem_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // RISC-V addi x0,x0,0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    function automatic int word_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// rtl/inst_mem_ram.sv - simple dual-port storage, one write port and one registered read port
module inst_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_data holds between reads so the fetch output keeps its last word
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_loadable.sv
// rtl/inst_mem_loadable.sv - instruction memory with streamed program load and 1-cycle fetch
module inst_mem_loadable
    import inst_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(NOP_INST_DEFAULT),
    localparam int               CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [CNT_W-1:0]  load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] inst_code,
    output logic              fetch_err,
    output logic              busy
);

    localparam int                IDX_W      = $clog2(DEPTH);
    localparam int                SHIFT      = word_shift(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SHIFT) - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(DEPTH - 1);

    state_t            state;
    logic              full_hold;
    logic              nop_sel;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] index_full;
    logic              addr_err;
    logic              fetch_accept;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    // Wrapping subtraction makes addresses below BASE_ADDR land far out of range
    assign offset       = fetch_addr - BASE_ADDR;
    assign index_full   = offset >> SHIFT;
    assign addr_err     = ((offset & ALIGN_MASK) != '0) || ((index_full >> IDX_W) != '0);
    assign fetch_accept = fetch_req && (state == RUN);
    assign rd_en        = fetch_accept && !addr_err;
    assign wr_en        = load_valid && load_ready;
    assign inst_code    = nop_sel ? NOP_INST : rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            full_hold   <= 1'b0;
            load_ready  <= 1'b0;
            load_count  <= '0;
            busy        <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            nop_sel     <= 1'b1;
        end else begin
            fetch_valid <= fetch_accept;
            if (fetch_accept) begin
                fetch_err <= addr_err;
                nop_sel   <= addr_err;
            end
            case (state)
                RUN: begin
                    // After a full load, load_en must drop before a new session may start
                    if (!load_en) begin
                        full_hold <= 1'b0;
                    end else if (!full_hold) begin
                        state      <= LOAD;
                        load_count <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        load_count <= load_count + 1'b1;
                    end
                    if (!load_en || (wr_en && (load_count == LAST_CNT))) begin
                        state      <= RUN;
                        load_ready <= 1'b0;
                        busy       <= 1'b0;
                        full_hold  <= load_en;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // The write pointer is the low part of load_count; it never wraps
    inst_mem_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(load_count[IDX_W-1:0]),
        .wr_data(load_data),
        .rd_en  (rd_en),
        .rd_addr(index_full[IDX_W-1:0]),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_inst_mem_loadable.sv
// tb/tb_inst_mem_loadable.sv - scoreboard bench for inst_mem_loadable (256-word and 8-word instances)
module tb_inst_mem_loadable;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_en    [2];
    logic        load_valid [2];
    logic [31:0] load_data  [2];
    logic        load_ready [2];
    logic        fetch_req  [2];
    logic [31:0] fetch_addr [2];
    logic        fetch_valid[2];
    logic [31:0] inst_code  [2];
    logic        fetch_err  [2];
    logic        busy       [2];
    logic [8:0]  lc0;
    logic [3:0]  lc1;

    int checks = 0;
    int errors = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_mem [2][256];
    bit          m_wr  [2][256];
    bit          m_load[2];
    bit          m_hold[2];
    int          m_count[2];
    bit          wrote[2];

    always #5 clk = ~clk;

    inst_mem_loadable #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .BASE_ADDR(32'h0), .NOP_INST(NOP)) u_big (
        .clk(clk), .reset(reset), .load_en(load_en[0]), .load_valid(load_valid[0]),
        .load_data(load_data[0]), .load_ready(load_ready[0]), .load_count(lc0),
        .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]), .fetch_valid(fetch_valid[0]),
        .inst_code(inst_code[0]), .fetch_err(fetch_err[0]), .busy(busy[0])
    );

    inst_mem_loadable #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .BASE_ADDR(32'h100), .NOP_INST(NOP)) u_small (
        .clk(clk), .reset(reset), .load_en(load_en[1]), .load_valid(load_valid[1]),
        .load_data(load_data[1]), .load_ready(load_ready[1]), .load_count(lc1),
        .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]), .fetch_valid(fetch_valid[1]),
        .inst_code(inst_code[1]), .fetch_err(fetch_err[1]), .busy(busy[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 8;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic int get_count(input int d);
        return (d == 0) ? int'(lc0) : int'(lc1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_fetch(input int d, input logic [31:0] addr);
        logic [31:0] off;
        logic [31:0] idx;
        exp_t        e;
        off = addr - base_of(d);
        idx = off >> 2;
        e.err = (off[1:0] != 2'b00) || (idx >= 32'(depth_of(d)));
        e.data = NOP;
        e.chk_data = 1'b1;
        if (!e.err) begin
            e.data = m_mem[d][idx[7:0]];
            e.chk_data = m_wr[d][idx[7:0]];
        end
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    // Advance one clock edge, updating the reference model with the inputs currently driven
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            wrote[d] = 1'b0;
            if (!m_load[d]) begin
                if (fetch_req[d]) push_fetch(d, fetch_addr[d]);
                if (!load_en[d]) m_hold[d] = 1'b0;
                else if (!m_hold[d]) begin
                    m_load[d] = 1'b1;
                    m_count[d] = 0;
                end
            end else begin
                if (load_valid[d] && m_count[d] < depth_of(d)) begin
                    m_mem[d][m_count[d]] = load_data[d];
                    m_wr[d][m_count[d]] = 1'b1;
                    m_count[d]++;
                    wrote[d] = 1'b1;
                end
                if (!load_en[d]) m_load[d] = 1'b0;
                else if (m_count[d] == depth_of(d)) begin
                    m_load[d] = 1'b0;
                    m_hold[d] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_load[d]));
            chk($sformatf("load_ready%0d", d), 32'(load_ready[d]),
                32'(m_load[d] && (m_count[d] < depth_of(d))));
            chk($sformatf("load_count%0d", d), 32'(get_count(d)), 32'(m_count[d]));
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            fetch_req[d] = 1'b0;
            load_valid[d] = 1'b0;
        end
        step();
    endtask

    task automatic issue(input int d, input logic [31:0] a);
        fetch_req[d] = 1'b1;
        fetch_addr[d] = a;
        step();
    endtask

    task automatic check_reset_values();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_inst_code%0d", d), inst_code[d], NOP);
            chk($sformatf("rst_fetch_err%0d", d), 32'(fetch_err[d]), 32'd0);
            chk($sformatf("rst_fetch_valid%0d", d), 32'(fetch_valid[d]), 32'd0);
            chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("rst_load_ready%0d", d), 32'(load_ready[d]), 32'd0);
            chk($sformatf("rst_load_count%0d", d), 32'(get_count(d)), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_load[d] = 1'b0;
            m_hold[d] = 1'b0;
            m_count[d] = 0;
        end
        #1;
        chk("mid_reset_busy", 32'(busy[0]), 32'd0);
        chk("mid_reset_count", 32'(lc0), 32'd0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            load_en[d] = 1'b0;
            load_valid[d] = 1'b0;
            fetch_req[d] = 1'b0;
        end
        reset = 1'b1;
    endtask

    task automatic load_words(input int d, input int n, input bit gaps, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w;
        load_en[d] = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            case (i)
                0: w = w0;
                1: w = w1;
                2: w = w2;
                3: w = w3;
                default: w = $urandom;
            endcase
            wrote[d] = 1'b0;
            for (int t = 0; t < 20 && !wrote[d]; t++) begin
                load_valid[d] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                load_data[d] = load_valid[d] ? w : $urandom;
                step();
            end
        end
        load_valid[d] = 1'b0;
        load_en[d] = 1'b0;
        step();
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        logic [31:0] a;
        int          idx;
        idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 19) % depth_of(d)
                                          : $urandom_range(0, depth_of(d) - 1);
        a = base_of(d) + 32'(idx) * 4;
        case ($urandom_range(0, 4))
            1: a = a + 32'($urandom_range(1, 3));
            2: a = base_of(d) + 32'(depth_of(d) + $urandom_range(0, 100)) * 4;
            3: a = base_of(d) - 32'($urandom_range(1, 8)) * 4;
            default: ;
        endcase
        return a;
    endfunction

    task automatic mon_one(input int d);
        exp_t e;
        bit   empty;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected%0d: fetch_valid=1 expected no response at %0t", d, $time);
        end else begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("sb_fetch_err%0d", d), 32'(fetch_err[d]), 32'(e.err));
            if (e.chk_data) chk($sformatf("sb_inst_code%0d", d), inst_code[d], e.data);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_valid[0] === 1'b1) mon_one(0);
        if (fetch_valid[1] === 1'b1) mon_one(1);
    end

    initial begin
        int acc;
        for (int d = 0; d < 2; d++) begin
            load_en[d] = 1'b0;
            load_valid[d] = 1'b0;
            load_data[d] = '0;
            fetch_req[d] = 1'b0;
            fetch_addr[d] = '0;
            m_load[d] = 1'b0;
            m_hold[d] = 1'b0;
            m_count[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b1;
        idle();

        issue(0, 32'h0);
        chk("rst_fetch_valid_next", 32'(fetch_valid[0]), 32'd1);
        idle();

        load_words(0, 4, 1'b1, 32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013);
        issue(0, 32'h0);
        issue(0, 32'h4);
        issue(0, 32'h8);
        issue(0, 32'hC);
        idle();
        chk("prog_load_count", 32'(lc0), 32'd4);

        issue(0, 32'h402);
        issue(0, 32'h400);
        idle();
        chk("hold_fetch_err", 32'(fetch_err[0]), 32'd1);
        chk("hold_inst_code", inst_code[0], NOP);
        chk("hold_fetch_valid", 32'(fetch_valid[0]), 32'd0);

        load_words(0, 16, 1'b1, $urandom, $urandom, $urandom, $urandom);
        load_words(1, 5, 1'b1, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 40; i++) begin
            fetch_req[0] = ($urandom_range(0, 3) != 0);
            fetch_addr[0] = rand_addr(0);
            fetch_req[1] = ($urandom_range(0, 3) != 0);
            fetch_addr[1] = rand_addr(1);
            step();
        end
        idle();

        load_en[1] = 1'b1;
        step();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            load_valid[1] = 1'b1;
            load_data[1] = $urandom;
            step();
            acc += int'(wrote[1]);
        end
        chk("fill_accepts", 32'(acc), 32'd8);
        chk("fill_busy", 32'(busy[1]), 32'd0);
        chk("fill_load_ready", 32'(load_ready[1]), 32'd0);
        chk("fill_load_count", 32'(lc1), 32'd8);
        issue(1, 32'h11C);
        issue(1, 32'h120);
        load_en[1] = 1'b0;
        idle();

        load_en[0] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            load_valid[0] = 1'b1;
            load_data[0] = $urandom;
            step();
        end
        load_data[0] = $urandom;
        do_reset();
        idle();
        for (int i = 0; i < 4; i++) issue(0, 32'(i * 4));
        idle();

        load_en[0] = 1'b1;
        issue(0, 32'h8);
        issue(0, 32'h4);
        chk("load_fetch_dropped", 32'(fetch_valid[0]), 32'd0);
        load_en[0] = 1'b0;
        idle();
        idle();

        chk("sb_drain0", 32'(q0.size()), 32'd0);
        chk("sb_drain1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised instruction memory with a run-time program-load port and a registered, handshaked fetch port. Successor to the fixed 32-bit instruction store: depth, word width and base address are parameters; a program is streamed in through a load handshake instead of being fixed at elaboration. The fetch stage of the RISC-V core reads it; a testbench or boot loader drives the load port.

## Interface
- DATA_W, 32, instruction word width; power of two, at least 8.
- DEPTH, 256, number of words; power of two.
- ADDR_W, 32, fetch byte-address width.
- BASE_ADDR, 0, byte address of word 0; DATA_W/8-aligned.
- NOP_INST, 32'h0000_0013, word returned on faulted fetch and at reset; RISC-V addi x0,x0,0.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- load_en  in  1  level; requests and holds LOAD mode.
- load_valid  in  1  a load word is presented.
- load_data  in  DATA_W  word to store.
- load_ready  out  1  block accepts load_data this cycle.
- load_count  out  $clog2(DEPTH)+1  words written in the current or last load session.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_valid  out  1  inst_code and fetch_err are valid.
- inst_code  out  DATA_W  fetched instruction.
- fetch_err  out  1  the fetch was misaligned or out of range.
- busy  out  1  block is in LOAD.

## Operation
- FSM has two states, RUN and LOAD. Reset enters RUN.
- RUN -> LOAD when load_en=1. The write pointer and load_count clear to 0 on entry.
- LOAD -> RUN when load_en=0, or on the cycle after the write that brings load_count to DEPTH.
- load_ready = (state==LOAD) && (load_count < DEPTH).
- A write happens when load_valid && load_ready. It stores mem[ptr] <= load_data, and ptr and load_count each increment by 1.
- load_data is ignored while load_ready=0.
- Fetch requests are accepted only in RUN. A fetch_req in LOAD is dropped with no response.
- Word index = (fetch_addr - BASE_ADDR) >> log2(DATA_W/8), computed modulo 2^ADDR_W.
- fetch_err=1 when fetch_addr is not aligned to DATA_W/8, or when the index is >= DEPTH. This also covers addresses below BASE_ADDR, because the subtraction wraps.
  - On error, inst_code = NOP_INST.
  - Otherwise, inst_code = mem[index].
- Memory contents are not reset. Words written before a reset or an aborted load are retained.
- Reading a word that has never been written returns X in simulation. The bench must not check such reads.

## Timing
- Reset values: state=RUN, load_ready=0, load_count=0, busy=0, fetch_valid=0, inst_code=NOP_INST, fetch_err=0.
- Fetch latency is 1 cycle. fetch_req accepted at edge N gives fetch_valid=1 and data during cycle N+1.
- Back-to-back requests give one response per cycle. There is no backpressure on fetch.
- With no accepted request, fetch_valid=0 and inst_code/fetch_err hold their last values.
- A request accepted in the same cycle that load_en rises is still answered, with pre-load data. busy rises in the next cycle.
- busy = (state==LOAD). It is registered.
- A write takes effect at the accepting edge. A fetch issued in the first RUN cycle after LOAD sees all written words.
- Full memory: the write that reaches DEPTH is accepted. load_ready=0 from the next cycle and the state returns to RUN. Further load_valid is ignored. load_count holds at DEPTH until the next LOAD entry.
- Reset asserted mid-load: the FSM goes to RUN at once, load_count=0, and no partial word is written.
- The pointer never wraps. A new session always restarts at word 0.

## Structure
- Package inst_mem_pkg holds:
  - the state enum {RUN, LOAD};
  - the NOP_INST default;
  - a localparam function computing the word-index shift.
- Sub-module inst_mem_ram holds the storage:
  - simple dual-port, one write port and one synchronous read port;
  - no reset;
  - DATA_W/DEPTH parameters.
- The top level holds the FSM, pointer, address decode and error logic.

## Test plan
- Reset: drive reset=0, then release. Check all outputs at their reset values; fetch of 0x0 -> fetch_valid=1 next cycle.
- Load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013, then drop load_en.
  - Fetch 0x0, 0x4, 0x8, 0xC back-to-back.
  - Expect those words on 4 consecutive cycles, with fetch_err=0 and load_count=4.
- Faulted fetches (DEPTH=256, BASE_ADDR=0):
  - fetch 0x402 -> fetch_err=1, inst_code=0x00000013;
  - fetch 0x400 -> fetch_err=1.
- Fill: DEPTH=8, stream 10 words with load_en held.
  - Expect 8 accepts, then load_ready=0 and busy=0.
  - load_count=8; word 7 reads back correctly.
- Disruptions:
  - assert reset=0 after 3 of 6 load words -> state RUN, load_count=0, words 0-2 readable;
  - fetch_req during LOAD -> no fetch_valid.
